// File: rtl/uart_hex_rx.sv
// uart_hex_rx
//
// Receive side of the temperature-sensor UART link. Deserialises an 8N1 stream,
// parses lines of DIGITS ASCII hex digits (most significant nibble first) ended
// by CR or LF, and presents the recovered binary value with a one-cycle strobe.
//
// Ports
//   clk            system clock, single domain
//   reset_n        asynchronous active-low reset
//   uart_rx_i      serial line, idle high, asynchronous to clk
//   value_o        last valid parsed value, holds between updates
//   value_valid_o  one-cycle pulse when value_o is updated
//   frame_err_o    one-cycle pulse when a stop bit is sampled low
//   format_err_o   one-cycle pulse when a malformed line is rejected

module uart_hex_rx #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned DIGITS    = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  uart_rx_i,
  output logic [4*DIGITS-1:0]   value_o,
  output logic                  value_valid_o,
  output logic                  frame_err_o,
  output logic                  format_err_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned TW           = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW           = $clog2(DIGITS + 1);
  localparam int unsigned VW           = 4 * DIGITS;

  localparam logic [TW-1:0] HalfLast = TW'(HALF_BIT - 1);
  localparam logic [TW-1:0] BitLast  = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CntFull  = CW'(DIGITS);

  // --------------------------------------------------------------------------
  // Synchroniser and edge detect
  // --------------------------------------------------------------------------
  logic rx_meta, rx_s, rx_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  logic rx_fall;
  assign rx_fall = rx_d & ~rx_s;

  // --------------------------------------------------------------------------
  // Receiver FSM
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  rx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_stb_q, byte_stb_d;
  logic          frame_stb_q, frame_stb_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      byte_stb_q  <= 1'b0;
      frame_stb_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_q      <= byte_d;
      byte_stb_q  <= byte_stb_d;
      frame_stb_q <= frame_stb_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_d      = byte_q;
    byte_stb_d  = 1'b0;
    frame_stb_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (rx_fall) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (timer_q == HalfLast) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          // A start bit that has already returned high was a glitch.
          state_d   = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (timer_q == BitLast) begin
          timer_d   = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (timer_q == BitLast) begin
          timer_d = '0;
          if (rx_s) begin
            byte_d     = shift_q;
            byte_stb_d = 1'b1;
            state_d    = StIdle;
          end else begin
            frame_stb_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        // Hold off start detection until the line has recovered.
        timer_d = '0;
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: begin
        timer_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Line parser
  // --------------------------------------------------------------------------
  // Returns {is_hex, nibble}.
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    logic [7:0] t;
    t = '0;
    if (b >= 8'h30 && b <= 8'h39) begin
      t = b - 8'h30;
      return {1'b1, t[3:0]};
    end else if (b >= 8'h41 && b <= 8'h46) begin
      t = b - 8'h37;
      return {1'b1, t[3:0]};
    end else if (b >= 8'h61 && b <= 8'h66) begin
      t = b - 8'h57;
      return {1'b1, t[3:0]};
    end
    return 5'b0_0000;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] acc_q, acc_d;
  logic          discard_q, discard_d;
  logic [VW-1:0] value_d;
  logic          valid_d, fmt_d, frame_d;

  logic [4:0] dec;
  logic       is_term;

  assign dec     = hex_decode(byte_q);
  assign is_term = (byte_q == 8'h0D) || (byte_q == 8'h0A);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      acc_q         <= '0;
      discard_q     <= 1'b0;
      value_o       <= '0;
      value_valid_o <= 1'b0;
      format_err_o  <= 1'b0;
      frame_err_o   <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      discard_q     <= discard_d;
      value_o       <= value_d;
      value_valid_o <= valid_d;
      format_err_o  <= fmt_d;
      frame_err_o   <= frame_d;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    discard_d = discard_q;
    value_d   = value_o;
    valid_d   = 1'b0;
    fmt_d     = 1'b0;
    frame_d   = frame_stb_q;

    if (frame_stb_q) begin
      // A broken frame invalidates whatever part of the line was collected.
      cnt_d     = '0;
      acc_d     = '0;
      discard_d = 1'b0;
    end else if (byte_stb_q) begin
      if (is_term) begin
        if (!discard_q) begin
          if (cnt_q == CntFull) begin
            value_d = acc_q;
            valid_d = 1'b1;
          end else if (cnt_q != '0) begin
            fmt_d = 1'b1;
          end
        end
        cnt_d     = '0;
        acc_d     = '0;
        discard_d = 1'b0;
      end else if (!discard_q) begin
        if (dec[4] && (cnt_q != CntFull)) begin
          acc_d = {acc_q[VW-5:0], dec[3:0]};
          cnt_d = cnt_q + 1'b1;
        end else begin
          // Report once, then swallow the rest of the line.
          fmt_d     = 1'b1;
          discard_d = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_hex_rx.sv
module tb_uart_hex_rx;

  // 32 clocks per bit keeps the run short while leaving a 16-cycle half bit.
  localparam int unsigned BAUD = 115200;
  localparam int unsigned CPB  = 32;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned FREQ = BAUD * CPB;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx;
  logic [23:0] value;
  logic        value_valid;
  logic        frame_err;
  logic        format_err;

  uart_hex_rx #(
    .CLK_FREQ (FREQ),
    .BAUD_RATE(BAUD),
    .DIGITS   (6)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .uart_rx_i    (rx),
    .value_o      (value),
    .value_valid_o(value_valid),
    .frame_err_o  (frame_err),
    .format_err_o (format_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int          n_valid = 0, n_fmt = 0, n_frame = 0, n_wide = 0, n_overlap = 0;
  int          valid_cyc = 0;
  logic [23:0] vals[$];
  logic        prev_v = 1'b0, prev_fm = 1'b0, prev_fr = 1'b0;

  always @(negedge clk) begin
    if (value_valid) begin
      n_valid++;
      valid_cyc = cyc;
      vals.push_back(value);
      if (prev_v) n_wide++;
    end
    if (format_err) begin
      n_fmt++;
      if (prev_fm) n_wide++;
    end
    if (frame_err) begin
      n_frame++;
      if (prev_fr) n_wide++;
    end
    if (value_valid && (format_err || frame_err)) n_overlap++;
    prev_v  = value_valid;
    prev_fm = format_err;
    prev_fr = frame_err;
  end

  int n_vec = 0;
  int n_err = 0;
  int byte_start = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stop_len, input logic stop_val);
    @(posedge clk);
    #1;
    byte_start = cyc;
    rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(CPB);
    end
    rx = stop_val;
    hold(stop_len);
  endtask

  task automatic send_str(input string s, input int stop_len);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], stop_len, 1'b1);
  endtask

  int base_v, base_f, base_fr, cr_start;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    rx      = 1'b1;
    hold(5);
    check("reset_value", 32'(value), 32'h0);
    check("reset_valid", 32'(value_valid), 32'h0);
    check("reset_frame", 32'(frame_err), 32'h0);
    check("reset_format", 32'(format_err), 32'h0);
    reset_n = 1'b1;
    hold(CPB);

    // Basic line, CR then LF: one value only.
    send_str("0001A4", CPB);
    send_byte(8'h0D, CPB, 1'b1);
    cr_start = byte_start;
    hold(2 * CPB);
    check("t1_valid_cnt", 32'(n_valid), 32'd1);
    check("t1_value", 32'(value), 32'h0001A4);
    // Input falls after edge 0; rx_s low after edge 2; start seen at edge 3;
    // stop sampled at 3+HALF+9*CPB; strobe one edge later.
    check("t1_latency", 32'(valid_cyc - cr_start), 32'(4 + HALF + 9 * CPB));
    send_byte(8'h0A, CPB, 1'b1);
    hold(2 * CPB);
    check("t1_lf_silent", 32'(n_valid), 32'd1);
    check("t1_no_fmt", 32'(n_fmt), 32'd0);
    check("t1_no_frame", 32'(n_frame), 32'd0);

    // Back-to-back lines with half-length stop bits.
    base_v = n_valid;
    send_str("00ff0a", HALF);
    send_byte(8'h0D, HALF, 1'b1);
    send_str("FFFFFF", HALF);
    send_byte(8'h0D, CPB, 1'b1);
    hold(2 * CPB);
    check("t2_valid_cnt", 32'(n_valid - base_v), 32'd2);
    check("t2_value0", 32'(vals[base_v]), 32'h00FF0A);
    check("t2_value1", 32'(vals[base_v + 1]), 32'hFFFFFF);
    check("t2_no_fmt", 32'(n_fmt), 32'd0);

    // Short line, long line, then a good line.
    base_v = n_valid;
    send_str("12345", CPB);
    send_byte(8'h0D, CPB, 1'b1);
    hold(2 * CPB);
    check("t3_short_fmt", 32'(n_fmt), 32'd1);
    check("t3_short_value", 32'(value), 32'hFFFFFF);
    send_str("1234567", CPB);
    send_byte(8'h0D, CPB, 1'b1);
    hold(2 * CPB);
    check("t3_long_fmt", 32'(n_fmt), 32'd2);
    check("t3_no_valid", 32'(n_valid - base_v), 32'd0);
    send_str("ABCDEF", CPB);
    send_byte(8'h0A, CPB, 1'b1);
    hold(2 * CPB);
    check("t3_value", 32'(value), 32'hABCDEF);
    check("t3_valid_cnt", 32'(n_valid - base_v), 32'd1);

    // Partial line, then a frame with a low stop bit and a long break.
    base_v = n_valid;
    base_f = n_fmt;
    send_str("12", CPB);
    send_byte(8'h33, CPB, 1'b0);
    hold(2000);
    rx = 1'b1;
    hold(2 * CPB);
    check("t4_frame_cnt", 32'(n_frame), 32'd1);
    send_str("000010", CPB);
    send_byte(8'h0D, CPB, 1'b1);
    hold(2 * CPB);
    check("t4_value", 32'(value), 32'h000010);
    check("t4_valid_cnt", 32'(n_valid - base_v), 32'd1);
    check("t4_no_fmt", 32'(n_fmt - base_f), 32'd0);
    check("t4_frame_once", 32'(n_frame), 32'd1);

    // Short low glitch on the idle line.
    base_v = n_valid;
    rx = 1'b0;
    hold(6);
    rx = 1'b1;
    hold(3 * CPB);
    check("t5_glitch_valid", 32'(n_valid - base_v), 32'd0);
    check("t5_glitch_fmt", 32'(n_fmt - base_f), 32'd0);
    check("t5_glitch_frame", 32'(n_frame), 32'd1);
    send_str("00000F", CPB);
    send_byte(8'h0D, CPB, 1'b1);
    hold(2 * CPB);
    check("t5_value", 32'(value), 32'h00000F);

    // Reset in the 4th data bit of the 3rd digit.
    send_str("C0", CPB);
    base_v  = n_valid;
    base_f  = n_fmt;
    base_fr = n_frame;
    @(posedge clk);
    #1;
    rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = logic'(8'h46 >> i);
      hold(CPB);
    end
    rx = 1'b0;
    hold(HALF);
    reset_n = 1'b0;
    rx      = 1'b1;
    hold(10);
    check("t6_rst_value", 32'(value), 32'h0);
    reset_n = 1'b1;
    hold(3 * CPB);
    check("t6_rst_pulses", 32'((n_valid - base_v) + (n_fmt - base_f) + (n_frame - base_fr)),
          32'd0);
    send_str("C0FFEE", CPB);
    send_byte(8'h0D, CPB, 1'b1);
    hold(2 * CPB);
    check("t6_value", 32'(value), 32'hC0FFEE);
    check("t6_valid_cnt", 32'(n_valid - base_v), 32'd1);
    check("t6_no_fmt", 32'(n_fmt - base_f), 32'd0);

    check("pulse_width", 32'(n_wide), 32'd0);
    check("pulse_overlap", 32'(n_overlap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
